// File: rtl/reset_sequencer_if.sv
// Control and status bundle between the reset sequencer and the logic that supervises it.
// The master drives the hold and request inputs; the slave side is the sequencer itself.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  i_extHold;
    logic                  i_swRstReq;
    logic                  o_swRstAck;
    logic [NUM_STAGES-1:0] o_outRst;
    logic                  o_rstDone;
    logic [7:0]            o_seqCount;

    modport master (
        output i_extHold,
        output i_swRstReq,
        input  o_swRstAck,
        input  o_outRst,
        input  o_rstDone,
        input  o_seqCount
    );

    modport slave (
        input  i_extHold,
        input  i_swRstReq,
        output o_swRstAck,
        output o_outRst,
        output o_rstDone,
        output o_seqCount
    );
endinterface

// File: rtl/reset_sequencer.sv
// Holds every downstream reset domain, then releases them one by one, lowest index first.
// The sequence restarts on an external hold or an accepted software request.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int CNT_W       = 8
) (
    input logic              i_clk,
    input logic              i_rst,
    reset_sequencer_if.slave bus
);
    localparam int IDX_W = 5;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    // r_idx reaching NUM_STAGES means every bit is released and completion is due next edge
    localparam logic [IDX_W-1:0] ALL_IDX   = IDX_W'(NUM_STAGES);

    typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_outRst;
    logic                  r_rstDone;
    logic                  r_swAck;
    logic [7:0]            r_seqCount;

    state_t                w_stateNext;
    logic [CNT_W-1:0]      w_cntNext;
    logic [IDX_W-1:0]      w_idxNext;
    logic [NUM_STAGES-1:0] w_outRstNext;
    logic                  w_rstDoneNext;
    logic                  w_swAckNext;
    logic [7:0]            w_seqCountNext;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_outRst   <= '1;
            r_rstDone  <= 1'b0;
            r_swAck    <= 1'b0;
            r_seqCount <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_idx      <= w_idxNext;
            r_outRst   <= w_outRstNext;
            r_rstDone  <= w_rstDoneNext;
            r_swAck    <= w_swAckNext;
            r_seqCount <= w_seqCountNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            HOLD: begin
                if (!bus.i_extHold && r_cnt == HOLD_LAST) w_stateNext = RELEASE;
            end
            RELEASE: begin
                if (bus.i_extHold)          w_stateNext = HOLD;
                else if (r_idx == ALL_IDX)  w_stateNext = DONE;
            end
            DONE: begin
                if (bus.i_extHold || bus.i_swRstReq) w_stateNext = HOLD;
            end
            default: w_stateNext = HOLD;
        endcase
    end

    always_comb begin
        w_cntNext      = r_cnt;
        w_idxNext      = r_idx;
        w_outRstNext   = r_outRst;
        w_rstDoneNext  = r_rstDone;
        w_swAckNext    = 1'b0;
        w_seqCountNext = r_seqCount;
        unique case (r_state)
            HOLD: begin
                w_outRstNext  = '1;
                w_rstDoneNext = 1'b0;
                if (bus.i_extHold) begin
                    w_cntNext = '0;
                    w_idxNext = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_cntNext       = '0;
                    w_outRstNext[0] = 1'b0;
                    w_idxNext       = IDX_W'(1);
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (bus.i_extHold) begin
                    w_cntNext     = '0;
                    w_idxNext     = '0;
                    w_outRstNext  = '1;
                    w_rstDoneNext = 1'b0;
                end else if (r_idx == ALL_IDX) begin
                    w_cntNext      = '0;
                    w_rstDoneNext  = 1'b1;
                    w_seqCountNext = r_seqCount + 8'd1;
                end else if (r_cnt == GAP_LAST) begin
                    w_cntNext = '0;
                    w_idxNext = r_idx + IDX_W'(1);
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (IDX_W'(i) == r_idx) w_outRstNext[i] = 1'b0;
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_outRstNext  = '0;
                w_rstDoneNext = 1'b1;
                // External hold outranks a software request; the request stays pending
                if (bus.i_extHold || bus.i_swRstReq) begin
                    w_swAckNext   = !bus.i_extHold;
                    w_cntNext     = '0;
                    w_idxNext     = '0;
                    w_outRstNext  = '1;
                    w_rstDoneNext = 1'b0;
                end
            end
            default: begin
                w_cntNext     = '0;
                w_idxNext     = '0;
                w_outRstNext  = '1;
                w_rstDoneNext = 1'b0;
            end
        endcase
    end

    assign bus.o_swRstAck = r_swAck;
    assign bus.o_outRst   = r_outRst;
    assign bus.o_rstDone  = r_rstDone;
    assign bus.o_seqCount = r_seqCount;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: a timeline model predicts every output change, a monitor matches DUT changes.
// The model counts consecutive unheld cycles and derives released bits from HOLD + k*GAP.
module tb_reset_sequencer;
    localparam int N        = 4;
    localparam int HOLD     = 16;
    localparam int GAP      = 8;
    localparam int DONE_LEN = HOLD + (N - 1) * GAP + 1;

    logic clk = 1'b0;
    logic rst;

    reset_sequencer_if #(.NUM_STAGES(N)) bus ();

    reset_sequencer #(
        .NUM_STAGES (N),
        .HOLD_CYCLES(HOLD),
        .STAGE_GAP  (GAP),
        .CNT_W      (8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint         t;
        logic [N-1:0]   outRst;
        logic           done;
        logic           ack;
        logic [7:0]     seq;
    } expRec_t;

    expRec_t expQ[$];
    int testsRun    = 0;
    int testsFailed = 0;
    bit armed       = 1'b0;

    int           runLen   = 0;
    bit           mDone    = 1'b0;
    bit           mAck     = 1'b0;
    logic [7:0]   mSeq     = 8'd0;
    logic [N-1:0] mOutPrev = '1;
    bit           mDonePrev = 1'b0;
    logic [7:0]   mSeqPrev = 8'd0;

    function automatic logic [N-1:0] releaseMask(int r);
        logic [N-1:0] m;
        m = '1;
        for (int k = 0; k < N; k++) begin
            if (r >= HOLD + k * GAP) m[k] = 1'b0;
        end
        return m;
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge and queue any predicted output change
    task automatic modelStep(bit r, bit e, bit q);
        logic [N-1:0] out;
        expRec_t rec;
        mAck = 1'b0;
        if (r) begin
            runLen = 0;
            mDone  = 1'b0;
            mSeq   = 8'd0;
        end else if (mDone) begin
            if (e) begin
                mDone  = 1'b0;
                runLen = 0;
            end else if (q) begin
                mAck   = 1'b1;
                mDone  = 1'b0;
                runLen = 0;
            end
        end else if (e) begin
            runLen = 0;
        end else begin
            runLen++;
            if (runLen == DONE_LEN) begin
                mDone = 1'b1;
                mSeq  = mSeq + 8'd1;
            end
        end
        out = mDone ? '0 : releaseMask(runLen);
        if (out !== mOutPrev || mDone !== mDonePrev || mSeq !== mSeqPrev || mAck) begin
            rec.t      = $time;
            rec.outRst = out;
            rec.done   = mDone;
            rec.ack    = mAck;
            rec.seq    = mSeq;
            expQ.push_back(rec);
        end
        mOutPrev  = out;
        mDonePrev = mDone;
        mSeqPrev  = mSeq;
    endtask

    task automatic applyStimulus(bit r, bit e, bit q);
        rst            = r;
        bus.i_extHold  = e;
        bus.i_swRstReq = q;
        @(posedge clk);
        modelStep(r, e, q);
        #2;
    endtask

    task automatic idle(int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic swReset(int holdAfter);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end while (!mAck && n < 300);
        repeat (holdAfter) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        logic [N-1:0] pOut;
        logic         pDone;
        logic [7:0]   pSeq;
        expRec_t      rec;
        pOut  = '1;
        pDone = 1'b0;
        pSeq  = 8'd0;
        wait (armed);
        forever begin
            @(negedge clk);
            if (bus.o_outRst !== pOut || bus.o_rstDone !== pDone ||
                bus.o_seqCount !== pSeq || bus.o_swRstAck !== 1'b0) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedEvent: got out=%h done=%b ack=%b seq=%0d, expected no change at time %0t",
                             bus.o_outRst, bus.o_rstDone, bus.o_swRstAck, bus.o_seqCount, $time);
                end else begin
                    rec = expQ.pop_front();
                    checkOutput("eventTime", 32'($time - rec.t), 32'd5);
                    checkOutput("eventValue",
                                32'({bus.o_outRst, bus.o_rstDone, bus.o_swRstAck, bus.o_seqCount}),
                                32'({rec.outRst, rec.done, rec.ack, rec.seq}));
                end
                pOut  = bus.o_outRst;
                pDone = bus.o_rstDone;
                pSeq  = bus.o_seqCount;
            end
        end
    end

    initial begin : stimulus
        bit rBit;
        bit eBit;
        bit reqLevel;
        bit ackSeen;
        rst            = 1'b1;
        bus.i_extHold  = 1'b0;
        bus.i_swRstReq = 1'b0;

        // Plain power-on sequence
        applyStimulus(1'b1, 1'b0, 1'b0);
        armed = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resetOutRst", 32'(bus.o_outRst), 32'hF);
        checkOutput("resetDone", 32'(bus.o_rstDone), 32'd0);
        checkOutput("resetSeq", 32'(bus.o_seqCount), 32'd0);
        checkOutput("resetAck", 32'(bus.o_swRstAck), 32'd0);
        idle(45);
        checkOutput("firstSeqOut", 32'(bus.o_outRst), 32'h0);
        checkOutput("firstSeqCount", 32'(bus.o_seqCount), 32'd1);

        // External hold right after reset delays the first release by ten cycles
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
        idle(15);
        checkOutput("holdDelayStill", 32'(bus.o_outRst), 32'hF);
        idle(1);
        checkOutput("holdDelayBit0", 32'(bus.o_outRst), 32'hE);
        idle(30);

        // Hold pulse mid-release aborts the partial sequence
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(30);
        checkOutput("midReleaseBefore", 32'(bus.o_outRst), 32'hC);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midReleaseAbort", 32'(bus.o_outRst), 32'hF);
        checkOutput("abortNotCounted", 32'(bus.o_seqCount), 32'd0);
        idle(45);

        // Software restart with the request held well past the acknowledge
        swReset(20);
        idle(45);
        checkOutput("swSeqCount", 32'(bus.o_seqCount), 32'd2);

        // Hold and request together: hold wins, acknowledge comes at the next DONE
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("bothNoAck", 32'(bus.o_swRstAck), 32'd0);
        checkOutput("bothHold", 32'(bus.o_outRst), 32'hF);
        swReset(0);
        checkOutput("pendingAck", 32'(bus.o_swRstAck), 32'd1);
        idle(45);

        // Reset in the middle of the release phase
        idle(5);
        swReset(0);
        idle(25);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("midRstOut", 32'(bus.o_outRst), 32'hF);
        checkOutput("midRstSeq", 32'(bus.o_seqCount), 32'd0);
        checkOutput("midRstDone", 32'(bus.o_rstDone), 32'd0);

        // One sequence from reset plus 255 software restarts wraps the counter
        idle(45);
        repeat (255) begin
            swReset(0);
            idle(45);
        end
        checkOutput("seqWrap", 32'(bus.o_seqCount), 32'd0);
        checkOutput("doneAfterWrap", 32'(bus.o_rstDone), 32'd1);

        // Randomised traffic
        reqLevel = 1'b0;
        ackSeen  = 1'b0;
        repeat (3000) begin
            rBit = ($urandom_range(0, 499) == 0);
            eBit = ($urandom_range(0, 59) == 0);
            if (!reqLevel && $urandom_range(0, 29) == 0) reqLevel = 1'b1;
            applyStimulus(rBit, eBit, reqLevel);
            if (mAck) ackSeen = 1'b1;
            if (reqLevel && ackSeen && $urandom_range(0, 2) == 0) begin
                reqLevel = 1'b0;
                ackSeen  = 1'b0;
            end
        end

        idle(3);
        @(negedge clk);
        #1;
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
